// File: rtl/battle_pkg.sv
// Shared types for the battle HUD: bar colour classes and HP animation states.
package battle_pkg;

    localparam int HP_W_DEF = 8;

    typedef enum logic [1:0] {
        ZONE_GREEN  = 2'd0,
        ZONE_YELLOW = 2'd1,
        ZONE_RED    = 2'd2
    } hp_zone_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FILL  = 2'd2
    } anim_state_t;

endpackage

// File: rtl/tick_divider.sv
// Counts frame_tick pulses modulo TICKS and pulses step on the last one.
module tick_divider #(
    parameter int unsigned TICKS = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    input  logic frame_tick,
    output logic step
);

    localparam logic [3:0] LAST = 4'(TICKS - 1);

    logic [3:0] cnt;
    logic       wrap;

    assign wrap = (cnt == LAST);
    assign step = enable && frame_tick && !clear && wrap;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && frame_tick) begin
            cnt <= wrap ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/hp_drain_anim.sv
// Steps the displayed HP toward the committed target, one point per divided frame tick.
module hp_drain_anim
    import battle_pkg::*;
#(
    parameter int unsigned TICKS_PER_STEP = 2,
    parameter int unsigned HP_W           = HP_W_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            frame_tick,
    input  logic            load,
    input  logic [HP_W-1:0] target_hp,
    input  logic [HP_W-1:0] max_hp,
    output logic [HP_W-1:0] disp_hp,
    output logic [1:0]      hp_zone,
    output logic            busy,
    output logic            done
);

    localparam logic [HP_W-1:0] ONE = 1;

    anim_state_t     state_q, state_d;
    logic [HP_W-1:0] disp_q, disp_d, tgt;
    logic            done_q, done_d;
    logic            step, cnt_en, cnt_clr;
    logic [HP_W+2:0] dx2, dx5, mx;
    hp_zone_t        zone;

    assign tgt     = (target_hp > max_hp) ? max_hp : target_hp;
    assign cnt_en  = (state_q != IDLE) && (disp_q != tgt);
    assign cnt_clr = load || (state_q == IDLE);

    tick_divider #(
        .TICKS(TICKS_PER_STEP)
    ) u_div (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (cnt_clr),
        .enable    (cnt_en),
        .frame_tick(frame_tick),
        .step      (step)
    );

    // Next state looks at the post-step value so busy drops on the landing edge.
    always_comb begin
        state_d = state_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        if (load) begin
            disp_d  = tgt;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tgt < disp_q) begin
                        state_d = DRAIN;
                    end else if (tgt > disp_q) begin
                        state_d = FILL;
                    end
                end
                DRAIN, FILL: begin
                    if (step) begin
                        disp_d = (tgt < disp_q) ? disp_q - ONE : disp_q + ONE;
                    end
                    if (disp_d == tgt) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (disp_d > tgt) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = FILL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            disp_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            disp_q  <= disp_d;
            done_q  <= done_d;
        end
    end

    assign dx2 = {2'b00, disp_q, 1'b0};
    assign dx5 = {3'b000, disp_q} + {1'b0, disp_q, 2'b00};
    assign mx  = {3'b000, max_hp};

    always_comb begin
        zone = ZONE_RED;
        if (dx2 > mx) begin
            zone = ZONE_GREEN;
        end else if (dx5 > mx) begin
            zone = ZONE_YELLOW;
        end
    end

    assign hp_zone = zone;
    assign disp_hp = disp_q;
    assign done    = done_q;
    assign busy    = !Reset && ((state_q != IDLE) || (disp_q != tgt));

endmodule

// File: tb/tb_hp_drain_anim.sv
// Directed bench for hp_drain_anim with TICKS_PER_STEP=2, HP_W=8.
module tb_hp_drain_anim;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic       load;
    logic [7:0] target_hp;
    logic [7:0] max_hp;
    logic [7:0] disp_hp;
    logic [1:0] hp_zone;
    logic       busy;
    logic       done;

    int n_vec;
    int n_bad;

    hp_drain_anim #(
        .TICKS_PER_STEP(2),
        .HP_W          (8)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .load      (load),
        .target_hp (target_hp),
        .max_hp    (max_hp),
        .disp_hp   (disp_hp),
        .hp_zone   (hp_zone),
        .busy      (busy),
        .done      (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] t, input logic [7:0] m);
        target_hp = t;
        max_hp    = m;
        load      = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic test_reset();
        do_load(8'd40, 8'd100);
        target_hp = 8'd10;
        cyc();
        tick();
        cyc();
        tick();
        cyc();
        tick();
        n_vec++;
        if (disp_hp !== 8'd39) begin
            n_bad++;
            $display("FAIL pre_reset_disp: got %0d want 39", disp_hp);
        end
        #2;
        Reset = 1'b1;
        #1;
        n_vec++;
        if (disp_hp !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || hp_zone !== 2'd2) begin
            n_bad++;
            $display("FAIL async_reset: disp=%0d busy=%b done=%b zone=%0d want 0 0 0 2",
                     disp_hp, busy, done, hp_zone);
        end
        cyc();
        Reset = 1'b0;
    endtask

    task automatic test_load();
        do_load(8'd100, 8'd100);
        n_vec++;
        if (disp_hp !== 8'd100 || hp_zone !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_snap: disp=%0d zone=%0d busy=%b done=%b want 100 0 0 0",
                     disp_hp, hp_zone, busy, done);
        end
        cyc();
        n_vec++;
        if (done !== 1'b0 || disp_hp !== 8'd100) begin
            n_bad++;
            $display("FAIL load_no_done: disp=%0d done=%b want 100 0", disp_hp, done);
        end
    endtask

    task automatic test_drain();
        int dones;
        logic [7:0] exp;
        dones = 0;
        target_hp = 8'd70;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_rise: got %b want 1", busy);
        end
        cyc();
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (done === 1'b1) dones++;
            exp = 8'(100 - k / 2);
            n_vec++;
            if (disp_hp !== exp || hp_zone !== 2'd0) begin
                n_bad++;
                $display("FAIL drain_step%0d: disp=%0d zone=%0d want %0d 0",
                         k, disp_hp, hp_zone, exp);
            end
            if (k < 60) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL drain_busy%0d: got %b want 1", k, busy);
                end
            end
            cyc();
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (busy !== 1'b0 || disp_hp !== 8'd70) begin
            n_bad++;
            $display("FAIL drain_end: busy=%b disp=%0d want 0 70", busy, disp_hp);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL drain_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_zones();
        logic [7:0] tv [5] = '{8'd51, 8'd50, 8'd21, 8'd20, 8'd0};
        logic [1:0] zv [5] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 5; i++) begin
            do_load(tv[i], 8'd100);
            n_vec++;
            if (hp_zone !== zv[i]) begin
                n_bad++;
                $display("FAIL zone_%0d: got %0d want %0d", tv[i], hp_zone, zv[i]);
            end
        end
        do_load(8'd5, 8'd0);
        n_vec++;
        if (hp_zone !== 2'd2 || disp_hp !== 8'd0) begin
            n_bad++;
            $display("FAIL zone_max0: zone=%0d disp=%0d want 2 0", hp_zone, disp_hp);
        end
    endtask

    task automatic test_reversal();
        int dones;
        int ticks;
        logic [7:0] prev;
        dones = 0;
        ticks = 0;
        do_load(8'd30, 8'd100);
        target_hp = 8'd10;
        cyc();
        tick();
        tick();
        tick();
        n_vec++;
        if (disp_hp !== 8'd29) begin
            n_bad++;
            $display("FAIL rev_pre: got %0d want 29", disp_hp);
        end
        target_hp = 8'd45;
        cyc();
        prev = disp_hp;
        while (disp_hp !== 8'd45 && ticks < 40) begin
            tick();
            ticks++;
            if (done === 1'b1) dones++;
            if (disp_hp < prev) begin
                n_vec++;
                n_bad++;
                $display("FAIL rev_monotonic: got %0d after %0d", disp_hp, prev);
            end
            prev = disp_hp;
        end
        n_vec++;
        if (ticks !== 31 || disp_hp !== 8'd45) begin
            n_bad++;
            $display("FAIL rev_ticks: ticks=%0d disp=%0d want 31 45", ticks, disp_hp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rev_done: dones=%0d busy=%b want 1 0", dones, busy);
        end
    endtask

    task automatic test_clamp();
        int dones;
        dones = 0;
        do_load(8'd100, 8'd100);
        target_hp = 8'd200;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL clamp_busy: got %b want 0", busy);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1 || busy !== 1'b0) dones++;
        end
        n_vec++;
        if (disp_hp !== 8'd100 || dones !== 0) begin
            n_bad++;
            $display("FAIL clamp_hold: disp=%0d activity=%0d want 100 0", disp_hp, dones);
        end
    endtask

    task automatic test_load_tick();
        do_load(8'd20, 8'd100);
        target_hp = 8'd0;
        cyc();
        tick();
        target_hp  = 8'd80;
        load       = 1'b1;
        frame_tick = 1'b1;
        cyc();
        load       = 1'b0;
        frame_tick = 1'b0;
        n_vec++;
        if (disp_hp !== 8'd80 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL load_tick: disp=%0d busy=%b done=%b want 80 0 0",
                     disp_hp, busy, done);
        end
        target_hp = 8'd78;
        cyc();
        tick();
        n_vec++;
        if (disp_hp !== 8'd80) begin
            n_bad++;
            $display("FAIL load_cnt_clear1: got %0d want 80", disp_hp);
        end
        tick();
        n_vec++;
        if (disp_hp !== 8'd79) begin
            n_bad++;
            $display("FAIL load_cnt_clear2: got %0d want 79", disp_hp);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_bad      = 0;
        Reset      = 1'b1;
        frame_tick = 1'b0;
        load       = 1'b0;
        target_hp  = 8'd0;
        max_hp     = 8'd100;
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();
        test_reset();
        test_load();
        test_drain();
        test_zones();
        test_reversal();
        test_clamp();
        test_load_tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
